// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, master limit and default abort timeout.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS     = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  always_comb begin
    int unsigned idx;
    logic [N-1:0] rot;
    idx         = 0;
    rot         = '0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr_ptr) + k) % N;
      rot = req >> idx;
      if (!grant_valid && rot[0]) begin
        grant       = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to 1-slave round-robin arbiter for the unified SRAM port.
// Optional slave-hang abort enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_sel,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byte_en,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            m_err,
  output logic                            s_sel,
  output logic                            s_we,
  output logic [DATA_W/8-1:0]             s_byte_en,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ack
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 1 || NUM_MASTERS > MAX_MASTERS || (DATA_W % 8) != 0 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("mem_arbiter: unsupported parameter set");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic             busy;
  logic             timeout_hit;
  logic             done;

  logic             sel_we;
  logic [BE_W-1:0]  sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req         (m_sel),
    .rr_ptr      (rr_ptr_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Extract the winning master's request fields from the flattened buses.
  assign sel_we    = 1'(m_we >> arb_grant);
  assign sel_be    = BE_W'(m_byte_en >> (32'(arb_grant) * BE_W));
  assign sel_addr  = ADDR_W'(m_addr >> (32'(arb_grant) * ADDR_W));
  assign sel_wdata = DATA_W'(m_wdata >> (32'(arb_grant) * DATA_W));

  assign busy = (state_q == BUSY);

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] to_cnt_q;

  // Counter holds the number of BUSY cycles already spent; the TIMEOUT-th cycle aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!busy) begin
      to_cnt_q <= '0;
    end else if (!s_ack) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = busy && !s_ack && (to_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A slave ack in the timeout cycle wins, so m_err only flags a genuine abort.
  assign done    = busy && (s_ack || timeout_hit);
  assign m_ack   = done ? (NUM_MASTERS'(1) << grant_q) : '0;
  assign m_rdata = (busy && s_ack) ? s_rdata : '0;
  assign m_err   = timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      s_sel     <= 1'b0;
      s_we      <= 1'b0;
      s_byte_en <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q   <= BUSY;
            grant_q   <= arb_grant;
            s_sel     <= 1'b1;
            s_we      <= sel_we;
            s_byte_en <= sel_be;
            s_addr    <= sel_addr;
            s_wdata   <= sel_wdata;
          end
        end
        BUSY: begin
          if (done) begin
            state_q  <= IDLE;
            s_sel    <= 1'b0;
            rr_ptr_q <= IDX_W'((32'(grant_q) + 1) % NUM_MASTERS);
          end
        end
        default: begin
          state_q <= IDLE;
          s_sel   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: 2-master instance against a transaction model, 4-master instance by literals.
module tb_mem_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]    m_sel, m_we, m_ack;
  logic [N*BW-1:0] m_byte_en;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic            s_sel, s_we, s_ack;
  logic [BW-1:0]   s_byte_en;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata, s_rdata;

  logic            auto_ack, man_ack;
  logic [DW-1:0]   man_rdata;

  logic [3:0]      m4_sel, m4_we, m4_ack;
  logic [15:0]     m4_be;
  logic [127:0]    m4_addr, m4_wdata;
  logic [31:0]     m4_rdata, s4_addr, s4_wdata;
  logic [3:0]      s4_be;
  logic            m4_err, s4_sel, s4_we;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] ack_log[$];

  always #5 clk = ~clk;

  // Bench-side slave: either acks every BUSY cycle or follows the directed man_ack.
  assign s_ack   = auto_ack ? s_sel : man_ack;
  assign s_rdata = auto_ack ? (s_addr ^ 32'hA5A5_A5A5) : man_rdata;

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_sel(m_sel), .m_we(m_we), .m_byte_en(m_byte_en),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_byte_en(s_byte_en), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  mem_arbiter #(.NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .m_sel(m4_sel), .m_we(m4_we), .m_byte_en(m4_be),
    .m_addr(m4_addr), .m_wdata(m4_wdata), .m_ack(m4_ack), .m_rdata(m4_rdata), .m_err(m4_err),
    .s_sel(s4_sel), .s_we(s4_we), .s_byte_en(s4_be), .s_addr(s4_addr), .s_wdata(s4_wdata),
    .s_rdata(32'h0), .s_ack(s4_sel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the 2-master instance.
  logic            md_busy, md_we;
  int              md_grant, md_rr, md_cyc;
  logic [BW-1:0]   md_be;
  logic [AW-1:0]   md_addr;
  logic [DW-1:0]   md_wdata;

  function automatic logic md_abort();
`ifdef MEM_ARBITER_TIMEOUT_EN
    return md_busy && !s_ack && (md_cyc == TO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int pick;
    if (!rst_n) begin
      md_busy <= 1'b0; md_rr <= 0; md_grant <= 0; md_cyc <= 0;
      md_we <= 1'b0; md_be <= '0; md_addr <= '0; md_wdata <= '0;
    end else if (!md_busy) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && m_sel[(md_rr + k) % N]) pick = (md_rr + k) % N;
      if (pick >= 0) begin
        md_busy  <= 1'b1;
        md_grant <= pick;
        md_cyc   <= 1;
        md_we    <= m_we[pick];
        md_be    <= BW'(m_byte_en >> (pick * BW));
        md_addr  <= AW'(m_addr >> (pick * AW));
        md_wdata <= DW'(m_wdata >> (pick * DW));
      end
    end else if (s_ack || md_abort()) begin
      md_busy <= 1'b0;
      md_rr   <= (md_grant + 1) % N;
    end else begin
      md_cyc <= md_cyc + 1;
    end
  end

  // Per-cycle comparison of the 2-master instance against the model.
  always @(negedge clk) begin : compare
    logic done_e;
    if (!rst_n) begin
      chk("rst_s_sel", 64'(s_sel), 64'(0));
      chk("rst_m_ack", 64'(m_ack), 64'(0));
      chk("rst_s_addr", 64'(s_addr), 64'(0));
      chk("rst_m_rdata", 64'(m_rdata), 64'(0));
      chk("rst_m_err", 64'(m_err), 64'(0));
    end else begin
      done_e = md_busy && (s_ack || md_abort());
      chk("s_sel", 64'(s_sel), 64'(md_busy));
      if (md_busy) begin
        chk("s_we", 64'(s_we), 64'(md_we));
        chk("s_byte_en", 64'(s_byte_en), 64'(md_be));
        chk("s_addr", 64'(s_addr), 64'(md_addr));
        chk("s_wdata", 64'(s_wdata), 64'(md_wdata));
      end
      chk("m_ack", 64'(m_ack), done_e ? 64'(1) << md_grant : 64'(0));
      chk("m_rdata", 64'(m_rdata), (md_busy && s_ack) ? 64'(s_rdata) : 64'(0));
      chk("m_err", 64'(m_err), 64'(md_abort()));
      if (m_ack != '0) ack_log.push_back(m_ack);
    end
  end

  task automatic wait_ack4(output logic [3:0] a);
    a = '0;
    for (int i = 0; i < 10 && a == 4'b0; i++) begin
      @(negedge clk);
      if (m4_ack != 4'b0) a = m4_ack;
    end
    if (a == 4'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ack4: no ack within 10 cycles at %0t", $time);
    end
    tick();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] a4;
    rst_n = 1'b0; m_sel = '0; m_we = '0; m_byte_en = '0; m_addr = '0; m_wdata = '0;
    auto_ack = 1'b0; man_ack = 1'b0; man_rdata = '0;
    m4_sel = '0; m4_we = '0; m4_be = '1; m4_wdata = '0;
    m4_addr = {32'h30, 32'h20, 32'h10, 32'h00};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Master 0 read at 0x10 with all-zero byte mask; slave acks in cycle 3.
    m_sel = 2'b01; m_we = 2'b00; m_byte_en[3:0] = 4'b0000; m_addr[31:0] = 32'h0000_0010;
    @(negedge clk);
    chk("t1_c0_s_sel", 64'(s_sel), 64'(0));
    tick(); @(negedge clk);
    chk("t1_c1_s_sel", 64'(s_sel), 64'(1));
    chk("t1_c1_s_addr", 64'(s_addr), 64'h10);
    tick(); tick();
    man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_c3_s_sel", 64'(s_sel), 64'(1));
    chk("t1_c3_m_ack", 64'(m_ack), 64'b01);
    chk("t1_c3_m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    tick();
    man_ack = 1'b0; m_sel = 2'b00;
    @(negedge clk);
    chk("t1_c4_s_sel", 64'(s_sel), 64'(0));

    // Slave ack while idle is ignored.
    tick();
    man_ack = 1'b1; man_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("idle_ack_m_ack", 64'(m_ack), 64'(0));
    chk("idle_ack_m_rdata", 64'(m_rdata), 64'(0));
    tick();
    man_ack = 1'b0;
    tick();

    // Reset in the middle of a transaction.
    m_sel = 2'b10; m_addr[63:32] = 32'h80;
    tick();
    @(negedge clk);
    chk("rst_pre_s_sel", 64'(s_sel), 64'(1));
    #2 rst_n = 1'b0;
    man_ack = 1'b1;
    #1;
    chk("rst_async_s_sel", 64'(s_sel), 64'(0));
    chk("rst_async_m_ack", 64'(m_ack), 64'(0));
    man_ack = 1'b0; m_sel = 2'b00;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    // Both masters requesting continuously: grants alternate starting at master 0.
    auto_ack = 1'b1;
    m_addr = {32'h0000_0200, 32'h0000_0100};
    m_sel = 2'b11;
    ack_log.delete();
    repeat (13) tick();
    m_sel = 2'b00;
    repeat (4) tick();
    chk("rr_ack_count_ge4", 64'(ack_log.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order_%0d", i), 64'(ack_log[i]), (i % 2 == 0) ? 64'b01 : 64'b10);

    // Master 1 write; request inputs change after the grant.
    auto_ack = 1'b0;
    m_we = 2'b10; m_byte_en[7:4] = 4'b0011; m_addr[63:32] = 32'h40; m_wdata[63:32] = 32'h1234_5678;
    m_sel = 2'b10;
    tick();
    m_we = 2'b00; m_byte_en[7:4] = 4'b1111; m_addr[63:32] = 32'hFFFF_FFF0; m_wdata[63:32] = '0;
    tick(); @(negedge clk);
    chk("t3_s_addr", 64'(s_addr), 64'h40);
    chk("t3_s_wdata", 64'(s_wdata), 64'h1234_5678);
    chk("t3_s_byte_en", 64'(s_byte_en), 64'b0011);
    chk("t3_s_we", 64'(s_we), 64'(1));
    tick();
    man_ack = 1'b1; man_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("t3_m_ack", 64'(m_ack), 64'b10);
    chk("t3_m_err", 64'(m_err), 64'(0));
    tick();
    man_ack = 1'b0; m_sel = 2'b00;
    tick();

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Hung slave aborts on the 4th BUSY cycle; master 0 drops sel after grant.
    m_sel = 2'b01; man_rdata = 32'hCAFE_0001;
    tick();
    m_sel = 2'b00;
    tick(); tick(); tick();
    @(negedge clk);
    chk("to_m_ack", 64'(m_ack), 64'b01);
    chk("to_m_err", 64'(m_err), 64'(1));
    chk("to_m_rdata", 64'(m_rdata), 64'(0));
    tick(); @(negedge clk);
    chk("to_after_s_sel", 64'(s_sel), 64'(0));
    // Ack in the timeout cycle wins.
    m_sel = 2'b01;
    tick();
    m_sel = 2'b00;
    tick(); tick(); tick();
    man_ack = 1'b1;
    @(negedge clk);
    chk("to_race_m_ack", 64'(m_ack), 64'b01);
    chk("to_race_m_err", 64'(m_err), 64'(0));
    chk("to_race_m_rdata", 64'(m_rdata), 64'hCAFE_0001);
    tick();
    man_ack = 1'b0;
    tick();
`endif

    // 4-master instance: master 2 alone (skips 0,1), then 2 and 3 with rr_ptr = 3.
    m4_sel = 4'b0100;
    wait_ack4(a4);
    chk("m4_skip_to_2", 64'(a4), 64'b0100);
    m4_sel = 4'b0000;
    tick();
    m4_sel = 4'b1100;
    wait_ack4(a4);
    chk("m4_first_3", 64'(a4), 64'b1000);
    m4_sel = 4'b0100;
    wait_ack4(a4);
    chk("m4_second_2", 64'(a4), 64'b0100);
    m4_sel = 4'b0000;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
